// File: rtl/bsg_cycle_delta_pkg.sv
// Shared types for the cycle-delta reader: FSM states, buffer entry layout and its reset value.
package bsg_cycle_delta_pkg;

  localparam int unsigned cdr_width_lp = 16;

  typedef enum logic {
    UNPRIMED = 1'b0,
    PRIMED   = 1'b1
  } cdr_state_e;

  typedef struct packed {
    logic                    first;
    logic [cdr_width_lp-1:0] delta;
  } cdr_entry_s;

  localparam cdr_entry_s cdr_entry_reset_lp = '{first: 1'b0, delta: '0};

endpackage

// File: rtl/bsg_cycle_delta_fifo.sv
// Small power-of-two entry FIFO with registered full/empty; push and pop may coincide at any
// occupancy, including full (the popped slot is the one being refilled).
module bsg_cycle_delta_fifo #(
  parameter int width_p = 17,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               full_o
);

  localparam int ptr_lp = $clog2(els_p);

  logic [els_p-1:0][width_p-1:0] mem_q;
  logic [ptr_lp-1:0]             wptr_q, wptr_d, rptr_q, rptr_d, wptr_inc, rptr_inc;
  logic                          full_q, full_d, empty_q, empty_d;
  logic                          push, pop;

  assign pop      = pop_i & ~empty_q;
  assign push     = push_i & (~full_q | pop);
  assign wptr_inc = wptr_q + ptr_lp'(1);
  assign rptr_inc = rptr_q + ptr_lp'(1);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (push) wptr_d = wptr_inc;
    if (pop)  rptr_d = rptr_inc;
    // Simultaneous push and pop leaves occupancy, and so both flags, unchanged.
    if (push && !pop) begin
      empty_d = 1'b0;
      full_d  = (wptr_inc == rptr_q);
    end else if (pop && !push) begin
      full_d  = 1'b0;
      empty_d = (rptr_inc == wptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) mem_q[wptr_q] <= data_i;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign v_o    = ~empty_q;
  assign data_o = mem_q[rptr_q];
  assign full_o = full_q;

endmodule

// File: rtl/bsg_cycle_delta_reader.sv
// Timestamps event strobes against a free-running cycle counter and queues modular deltas.
// Optional saturating drop counter on drops_o when BSG_CYCLE_DELTA_READER_DROP_CTR_EN is defined.
module bsg_cycle_delta_reader
  import bsg_cycle_delta_pkg::*;
#(
  parameter int width_p      = 16,
  parameter int els_p        = 2,
  parameter int drop_width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] ctr_i,
  input  logic               event_i,
  output logic               v_o,
  output logic [width_p-1:0] delta_o,
  output logic               first_o,
  input  logic               yumi_i
`ifdef BSG_CYCLE_DELTA_READER_DROP_CTR_EN
  ,
  output logic [drop_width_p-1:0] drops_o
`endif
);

  generate
    if (els_p < 2 || (els_p & (els_p - 1)) != 0) begin : g_bad_els
      $error("els_p must be a power of two >= 2");
    end
    if (drop_width_p < 1) begin : g_bad_drop
      $error("drop_width_p must be >= 1");
    end
  endgenerate

  cdr_state_e         state_q, state_d;
  logic [width_p-1:0] last_q, last_d;
  logic [width_p-1:0] push_delta;
  logic               full, pop, accept;

  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign pop        = yumi_i & v_o;
  assign accept     = event_i & (~full | pop);
  assign push_delta = (state_q == PRIMED) ? (ctr_i - last_q) : ctr_i;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (accept) begin
      state_d = PRIMED;
      last_d  = ctr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= UNPRIMED;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  bsg_cycle_delta_fifo #(
    .width_p(width_p + 1),
    .els_p  (els_p)
  ) fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (accept),
    .data_i   ({state_q == UNPRIMED, push_delta}),
    .pop_i    (pop),
    .v_o      (v_o),
    .data_o   ({first_o, delta_o}),
    .full_o   (full)
  );

`ifdef BSG_CYCLE_DELTA_READER_DROP_CTR_EN
  logic [drop_width_p-1:0] drops_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      drops_q <= '0;
    else if (event_i && !accept && drops_q != '1)
      drops_q <= drops_q + drop_width_p'(1);
  end

  assign drops_o = drops_q;
`endif

endmodule

// File: tb/tb_bsg_cycle_delta_reader.sv
// Directed vector bench for bsg_cycle_delta_reader: table of per-cycle inputs and expected head.
module tb_bsg_cycle_delta_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] ctr = '0;
  logic        ev = 1'b0;
  logic        yumi = 1'b0;
  logic        v, first;
  logic [15:0] delta;
`ifdef BSG_CYCLE_DELTA_READER_DROP_CTR_EN
  logic [7:0]  drops;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bsg_cycle_delta_reader #(.width_p(16), .els_p(2), .drop_width_p(8)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .ctr_i    (ctr),
    .event_i  (ev),
    .v_o      (v),
    .delta_o  (delta),
    .first_o  (first),
    .yumi_i   (yumi)
`ifdef BSG_CYCLE_DELTA_READER_DROP_CTR_EN
    ,
    .drops_o  (drops)
`endif
  );

  always @(posedge clk)
    if (reset_n) assert (!(yumi && !v)) else $error("yumi_i asserted while v_o=0");

  typedef struct {
    logic        rst_n;
    logic        ev;
    logic [15:0] ctr;
    logic        yumi;
    logic        chk;
    logic        v;
    logic        f;
    logic [15:0] d;
    int          drops;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic [15:0] c, input logic y,
                     input logic ck, input logic ev_v, input logic ef, input logic [15:0] ed,
                     input int edr);
    vec_t t;
    t.rst_n = r; t.ev = e; t.ctr = c; t.yumi = y; t.chk = ck;
    t.v = ev_v; t.f = ef; t.d = ed; t.drops = edr;
    vq.push_back(t);
  endtask

  task automatic check(input string name, input logic ck, input logic ev_v, input logic ef,
                       input logic [15:0] ed, input int edr);
    checks++;
    if (ck) begin
      if ({v, first, delta} !== {ev_v, ef, ed}) begin
        errors++;
        $display("FAIL %s: got v=%b first=%b delta=%h, want v=%b first=%b delta=%h",
                 name, v, first, delta, ev_v, ef, ed);
      end
    end else if (v !== ev_v) begin
      errors++;
      $display("FAIL %s: got v=%b, want v=%b", name, v, ev_v);
    end
`ifdef BSG_CYCLE_DELTA_READER_DROP_CTR_EN
    checks++;
    if (int'(drops) != edr) begin
      errors++;
      $display("FAIL %s drops: got %0d, want %0d", name, drops, edr);
    end
`endif
  endtask

  initial begin
    //   rst ev  ctr      yumi chk v  f  delta    drops
    add(1, 1, 16'h0010, 0, 1, 1, 1, 16'h0010, 0);  // first event: absolute timestamp
    add(1, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);  // pop -> empty
    add(1, 1, 16'h0025, 0, 1, 1, 0, 16'h0015, 0);
    add(1, 1, 16'hFFF0, 1, 1, 1, 0, 16'hFFCB, 0);  // pop+push at one entry
    add(1, 1, 16'h0005, 1, 1, 1, 0, 16'h0015, 0);  // wrap
    add(1, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
    add(1, 1, 16'h00E0, 0, 1, 1, 0, 16'h00DB, 0);
    add(1, 1, 16'h00F0, 0, 1, 1, 0, 16'h00DB, 0);  // now full
    add(1, 1, 16'h0100, 0, 1, 1, 0, 16'h00DB, 1);  // dropped
    add(1, 0, 16'h0000, 1, 1, 1, 0, 16'h0010, 1);
    add(1, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1);
    add(1, 1, 16'h0130, 0, 1, 1, 0, 16'h0040, 1);  // spans the dropped event
    add(1, 1, 16'h0140, 0, 1, 1, 0, 16'h0040, 1);  // full again
    add(1, 1, 16'h0150, 1, 1, 1, 0, 16'h0010, 1);  // full + yumi: accepted
    add(1, 1, 16'h0160, 0, 1, 1, 0, 16'h0010, 2);  // still full: dropped
    add(1, 0, 16'h0000, 1, 1, 1, 0, 16'h0010, 2);
    add(1, 1, 16'h0170, 1, 1, 1, 0, 16'h0020, 2);  // single-entry pop+push
    add(1, 1, 16'h0170, 1, 1, 1, 0, 16'h0000, 2);  // zero delta is not a drop
    add(1, 1, 16'h0180, 0, 1, 1, 0, 16'h0000, 2);
    add(0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0);  // reset with two pending
    add(1, 1, 16'h0042, 0, 1, 1, 1, 16'h0042, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset", 1'b1, 1'b0, 1'b0, 16'h0000, 0);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      reset_n = vq[i].rst_n; ev = vq[i].ev; ctr = vq[i].ctr; yumi = vq[i].yumi;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vq[i].chk, vq[i].v, vq[i].f, vq[i].d, vq[i].drops);
    end

    // Streaming: one event per cycle with a pop every cycle, deltas of 3.
    for (int i = 0; i < 8; i++) begin
      reset_n = 1'b1; ev = 1'b1; yumi = 1'b1;
      ctr = 16'h0042 + 16'(3 * (i + 1));
      @(posedge clk);
      #1;
      check($sformatf("stream%0d", i), 1'b1, 1'b1, 1'b0, 16'h0003, 0);
    end

    // Drain and confirm the buffer empties.
    ev = 1'b0; yumi = 1'b1;
    @(posedge clk);
    #1;
    yumi = 1'b0;
    check("drain", 1'b0, 1'b0, 1'b0, 16'h0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/bsg_cycle_delta_reader.md
# bsg_cycle_delta_reader

Consumer of a free-running `bsg_cycle_counter` value: timestamps `event_i` strobes and emits the elapsed cycle count since the previous accepted event. The elapsed count is computed modulo 2^width_p, so counter wrap-around is handled. Results pass through a small elastic buffer with a valid/yumi handshake. It sits beside the cycle counter in profiling and perf-monitor paths, where the counter is the writer and this block is the reader.

## Interface
- width_p, 16, counter and delta width; must match the driving cycle counter.
- els_p, 2, output buffer depth; power of two, ≥2.
- drop_width_p, 8, drop-counter width; used only with the macro in Configuration.
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; one clock, reset is synchronous and active-low.
- ctr_i  in  width_p  current cycle-counter value.
- event_i  in  1  single-cycle event strobe; sampled every cycle.
- v_o  out  1  buffer head valid.
- delta_o  out  width_p  head payload: elapsed cycles, or an absolute timestamp when first_o=1.
- first_o  out  1  head is the first event since reset.
- yumi_i  in  1  consumer pops the head; legal only when v_o=1.
- drops_o  out  drop_width_p  saturating dropped-event count; present only with the macro.

## Operation
- FSM states:
  - UNPRIMED (reset state): no baseline held.
  - PRIMED: baseline last_r valid.
- Event accept condition: event_i=1 and (buffer not full, or yumi_i=1 in the same cycle).
- Accepted event in UNPRIMED: push {first=1, delta=ctr_i}; last_r<=ctr_i; go to PRIMED.
- Accepted event in PRIMED: push {first=0, delta=(ctr_i-last_r) mod 2^width_p}; last_r<=ctr_i.
- Dropped event (full, no yumi_i):
  - nothing is pushed;
  - last_r and the FSM state are unchanged, so the next accepted delta spans the dropped event.
- Event with ctr_i==last_r in PRIMED: delta 0 is pushed, not a drop.
- Buffer: FIFO ordering. Push and pop in the same cycle are allowed in every occupancy, including full and single-entry.
- yumi_i while v_o=0: illegal. The design ignores it, and the bench flags it as an assertion failure.
- Reset values, applied while reset_n_i=0 at a clock edge:
  - v_o=0, delta_o=0, first_o=0, drops_o=0;
  - state UNPRIMED, last_r=0;
  - buffer empty and storage zeroed.
- Reset mid-operation: pending entries are discarded with no handshake. The next accepted event reports first_o=1.

## Timing
- Latency event→output: an event accepted at edge N is visible on v_o/delta_o after edge N when the buffer was empty. There is no combinational path from event_i or ctr_i to any output.
- Outputs are registered buffer state. yumi_i affects only state at the next edge.
- Throughput: one event per cycle while the consumer pops every cycle.
- The full flag is registered. The accept decision uses the full flag and yumi_i combinationally.

## Configuration
- BSG_CYCLE_DELTA_READER_DROP_CTR_EN defined:
  - drops_o port exists;
  - it increments by 1 per dropped event and saturates at all-ones;
  - it clears only on reset.
- Not defined:
  - no drops_o port and no counter logic;
  - drops occur silently, with identical buffer and delta behaviour.

## Structure
- Package bsg_cycle_delta_pkg holds:
  - state enum {UNPRIMED, PRIMED};
  - entry struct {first, delta[width_p]}, parameterised through a localparam width default;
  - the reset constant for the entry.
- Sub-module bsg_cycle_delta_fifo: els_p-deep entry FIFO with ptrs and registered full/empty, and same-cycle push/pop on full. The top level holds the FSM, last_r, subtraction and drop counter.

## Test plan
- Reset released; event at ctr_i=0x0010 → next cycle v_o=1, first_o=1, delta_o=0x0010. yumi_i → v_o=0.
- PRIMED at 0x0010; event at 0x0025 → delta_o=0x0015, first_o=0.
- Wrap: baseline 0xFFF0, event at 0x0005 → delta_o=0x0015.
- Buffer full (2 entries, yumi_i=0); event at 0x0100 → dropped, drops_o=1. After popping, event at 0x0130 with prior baseline 0x00F0 → delta_o=0x0040.
- Buffer full; event coincident with yumi_i=1 → accepted, occupancy stays 2, drops_o unchanged.
- Two entries pending; reset_n_i=0 for one edge → v_o=0, drops_o=0. Next event at 0x0042 → first_o=1, delta_o=0x0042.
